reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 27 ++
 rtl/reg_file_rd_port.sv | 88 ++++++++
 rtl/reg_file.sv | 79 +++++++
 tb/tb_reg_file.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared definitions for the register file: default geometry, the
//   hard-wired zero-register address, the read-source selector used by the
//   read ports and the address legality helper.
//   Optional feature: REG_FILE_BYPASS_EN (write-to-read forwarding, see
//   reg_file_rd_port).
package reg_file_pkg;

    localparam int          DEF_WIDTH = 32;
    localparam int          DEF_DEPTH = 32;
    localparam int          DEF_AW    = 5;
    localparam int unsigned ZERO_ADDR = 0;

    // Where a read port takes its next data word from.
    typedef enum logic [1:0] {
        RD_ZERO   = 2'd0,
        RD_ARRAY  = 2'd1,
        RD_BYPASS = 2'd2
    } rd_src_e;

    // An address names real storage only if it is not the zero register
    // and lies inside the populated depth.
    function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
        return (addr != ZERO_ADDR) && (addr < depth);
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port
//   One registered read port: address range check, source select
//   (zero / array / same-cycle write data) and the RD/RV output registers.
//   Optional feature: REG_FILE_BYPASS_EN -- when defined, a read that hits
//   the address being written in the same cycle returns the new write data;
//   when undefined it returns the stored (pre-write) word.
// Ports
//   i_clk, i_rst_n   clock, async active-low reset
//   i_re, i_ra       read enable / read address
//   i_we, i_wa, i_wd write-side view, used only for forwarding
//   i_mem            current storage contents
//   o_rd, o_rv       registered read data / one-cycle read-valid
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_re,
    input  logic [AW-1:0]    i_ra,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wa,
    input  logic [WIDTH-1:0] i_wd,
    input  logic [WIDTH-1:0] i_mem [DEPTH],
    output logic [WIDTH-1:0] o_rd,
    output logic             o_rv
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             w_ra_ok;
    logic [IW-1:0]    w_idx;
    rd_src_e          w_src;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] r_rd;
    logic             r_rv;

    assign w_ra_ok = addr_ok(32'(i_ra), DEPTH);
    // Only the low bits index storage; out-of-range addresses never alias.
    assign w_idx   = w_ra_ok ? i_ra[IW-1:0] : '0;

    always_comb begin
        w_src = RD_ZERO;
        if (w_ra_ok) begin
            w_src = RD_ARRAY;
`ifdef REG_FILE_BYPASS_EN
            // w_ra_ok already excludes address 0, so a zero-register write
            // can never be forwarded.
            if (i_we && (i_wa == i_ra)) begin
                w_src = RD_BYPASS;
            end
`endif
        end
    end

`ifndef REG_FILE_BYPASS_EN
    logic w_unused_wr;
    assign w_unused_wr = ^{i_we, i_wa, i_wd};
`endif

    always_comb begin
        w_data = '0;
        case (w_src)
            RD_ARRAY:  w_data = i_mem[w_idx];
            RD_BYPASS: w_data = i_wd;
            default:   w_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd <= '0;
            r_rv <= 1'b0;
        end else begin
            r_rv <= i_re;
            if (i_re) begin
                r_rd <= w_data;
            end
        end
    end

    assign o_rd = r_rd;
    assign o_rv = r_rv;

endmodule

// File: rtl/reg_file.sv
// reg_file
//   DEPTH x WIDTH register file, one write port and two independent
//   registered read ports. Entry 0 is hard-wired to zero; writes to 0 or to
//   addresses >= DEPTH are dropped, reads of them return 0 with RV set.
//   Optional feature: REG_FILE_BYPASS_EN (same-cycle write forwarding to the
//   read ports; default build returns pre-write contents).
// Ports
//   CLK, RST_N         clock, async active-low reset (clears storage + outputs)
//   WE, WA, WD         write enable / address / data
//   RE1, RA1, RD1, RV1 read port 1 enable / address / data / valid
//   RE2, RA2, RD2, RV2 read port 2 enable / address / data / valid
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic             RE1,
    input  logic [AW-1:0]    RA1,
    input  logic             RE2,
    input  logic [AW-1:0]    RA2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic             RV1,
    output logic             RV2
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;
    logic [IW-1:0]    w_wa_idx;

    assign w_wr_ok  = WE && addr_ok(32'(WA), DEPTH);
    assign w_wa_idx = WA[IW-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[w_wa_idx] <= WD;
        end
    end

    reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_port1 (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_re    (RE1),
        .i_ra    (RA1),
        .i_we    (WE),
        .i_wa    (WA),
        .i_wd    (WD),
        .i_mem   (r_mem),
        .o_rd    (RD1),
        .o_rv    (RV1)
    );

    reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_port2 (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_re    (RE2),
        .i_ra    (RA2),
        .i_we    (WE),
        .i_wa    (WA),
        .i_wd    (WD),
        .i_mem   (r_mem),
        .o_rd    (RD2),
        .o_rv    (RV2)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
//   Self-checking bench for reg_file (WIDTH=32, DEPTH=32, AW=6 so that
//   out-of-range addresses can be driven). Honours REG_FILE_BYPASS_EN.
module tb_reg_file;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 6;

`ifdef REG_FILE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             WE;
    logic [AW-1:0]    WA;
    logic [WIDTH-1:0] WD;
    logic             RE1, RE2;
    logic [AW-1:0]    RA1, RA2;
    logic [WIDTH-1:0] RD1, RD2;
    logic             RV1, RV2;

    int checks = 0;
    int errors = 0;

    reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .WE    (WE),
        .WA    (WA),
        .WD    (WD),
        .RE1   (RE1),
        .RA1   (RA1),
        .RE2   (RE2),
        .RA2   (RA2),
        .RD1   (RD1),
        .RD2   (RD2),
        .RV1   (RV1),
        .RV2   (RV2)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain array of words plus the last value each port returned.
    logic [31:0] m_mem [32];
    logic [31:0] m_rd1, m_rd2;
    logic        m_rv1, m_rv2;

    function automatic logic [31:0] m_read(input int ra);
        if (ra == 0 || ra >= DEPTH) return 32'h0;
        if (BYP && WE && (32'(WA) == ra)) return WD;
        return m_mem[ra[4:0]];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        m_rd1 = 32'h0; m_rd2 = 32'h0; m_rv1 = 1'b0; m_rv2 = 1'b0;
    endtask

    // One clock: model evaluates what the DUT sees at the edge, then outputs settle.
    task automatic step();
        logic [31:0] n1, n2;
        @(posedge CLK);
        n1 = RE1 ? m_read(32'(RA1)) : m_rd1;
        n2 = RE2 ? m_read(32'(RA2)) : m_rd2;
        m_rd1 = n1; m_rd2 = n2; m_rv1 = RE1; m_rv2 = RE2;
        if (WE && WA != 0 && 32'(WA) < DEPTH) m_mem[WA[4:0]] = WD;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                         input logic re1, input logic [AW-1:0] ra1,
                         input logic re2, input logic [AW-1:0] ra2);
        WE = we; WA = wa; WD = wd; RE1 = re1; RA1 = ra1; RE2 = re2; RA2 = ra2;
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [5:0]  ra1;
        logic        re2;
        logic [5:0]  ra2;
        logic [31:0] e_rd1;
        logic        e_rv1;
        logic [31:0] e_rd2;
        logic        e_rv2;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] byp7;
        byp7 = BYP ? 32'h2102 : 32'h1111;
        //            we    wa     wd            re1   ra1    re2   ra2    rd1           rv1   rd2           rv2
        vecs[0]  = '{1'b0, 6'd0,  32'h0,       1'b1, 6'd3,  1'b0, 6'd0,  32'h0,       1'b1, 32'h0,       1'b0};
        vecs[1]  = '{1'b1, 6'd5,  32'h5432,    1'b0, 6'd0,  1'b0, 6'd0,  32'h0,       1'b0, 32'h0,       1'b0};
        vecs[2]  = '{1'b0, 6'd0,  32'h0,       1'b1, 6'd5,  1'b0, 6'd0,  32'h5432,    1'b1, 32'h0,       1'b0};
        vecs[3]  = '{1'b0, 6'd0,  32'h0,       1'b0, 6'd0,  1'b0, 6'd0,  32'h5432,    1'b0, 32'h0,       1'b0};
        vecs[4]  = '{1'b1, 6'd0,  32'h1234,    1'b0, 6'd0,  1'b0, 6'd0,  32'h5432,    1'b0, 32'h0,       1'b0};
        vecs[5]  = '{1'b0, 6'd0,  32'h0,       1'b0, 6'd0,  1'b1, 6'd0,  32'h5432,    1'b0, 32'h0,       1'b1};
        vecs[6]  = '{1'b1, 6'd7,  32'h1111,    1'b0, 6'd0,  1'b0, 6'd0,  32'h5432,    1'b0, 32'h0,       1'b0};
        vecs[7]  = '{1'b1, 6'd7,  32'h2102,    1'b1, 6'd7,  1'b0, 6'd0,  byp7,        1'b1, 32'h0,       1'b0};
        vecs[8]  = '{1'b0, 6'd0,  32'h0,       1'b1, 6'd7,  1'b0, 6'd0,  32'h2102,    1'b1, 32'h0,       1'b0};
        vecs[9]  = '{1'b0, 6'd0,  32'h0,       1'b1, 6'd5,  1'b1, 6'd5,  32'h5432,    1'b1, 32'h5432,    1'b1};
        vecs[10] = '{1'b0, 6'd0,  32'h0,       1'b1, 6'd40, 1'b0, 6'd0,  32'h0,       1'b1, 32'h5432,    1'b0};
        vecs[11] = '{1'b1, 6'd40, 32'hdead,    1'b0, 6'd0,  1'b1, 6'd40, 32'h0,       1'b0, 32'h0,       1'b1};
        vecs[12] = '{1'b0, 6'd0,  32'h0,       1'b1, 6'd8,  1'b1, 6'd31, 32'h0,       1'b1, 32'h0,       1'b1};

        // Reset, with activity requested while reset is held.
        RST_N = 1'b0;
        drive(1'b1, 6'd5, 32'hffff_ffff, 1'b1, 6'd5, 1'b1, 6'd5);
        m_reset();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("rst_rd1", RD1, 32'h0);
        chk("rst_rv1", 32'(RV1), 32'h0);
        chk("rst_rd2", RD2, 32'h0);
        chk("rst_rv2", 32'(RV2), 32'h0);
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, 6'd0);
        RST_N = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re1, vecs[i].ra1,
                  vecs[i].re2, vecs[i].ra2);
            step();
            chk($sformatf("vec%0d_rd1", i), RD1, vecs[i].e_rd1);
            chk($sformatf("vec%0d_rv1", i), 32'(RV1), 32'(vecs[i].e_rv1));
            chk($sformatf("vec%0d_rd2", i), RD2, vecs[i].e_rd2);
            chk($sformatf("vec%0d_rv2", i), 32'(RV2), 32'(vecs[i].e_rv2));
        end

        // Reset pulsed between edges while a read is pending.
        drive(1'b0, 6'd0, 32'h0, 1'b1, 6'd5, 1'b0, 6'd0);
        step();
        chk("pre_rst_rd1", RD1, 32'h5432);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_rd1", RD1, 32'h0);
        chk("async_rst_rv1", 32'(RV1), 32'h0);
        chk("async_rst_rd2", RD2, 32'h0);
        RST_N = 1'b1;
        m_reset();
        RE1 = 1'b0;
        step();
        chk("post_rst_rv1", 32'(RV1), 32'h0);
        chk("post_rst_rd1", RD1, 32'h0);
        drive(1'b0, 6'd0, 32'h0, 1'b1, 6'd5, 1'b1, 6'd7);
        step();
        chk("post_rst_e5_rd1", RD1, 32'h0);
        chk("post_rst_e5_rv1", 32'(RV1), 32'h1);
        chk("post_rst_e7_rd2", RD2, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 39)), $urandom(),
                  1'($urandom_range(0, 9) < 7), 6'($urandom_range(0, 39)),
                  1'($urandom_range(0, 9) < 7), 6'($urandom_range(0, 39)));
            step();
            chk($sformatf("rnd%0d_rd1", n), RD1, m_rd1);
            chk($sformatf("rnd%0d_rv1", n), 32'(RV1), 32'(m_rv1));
            chk($sformatf("rnd%0d_rd2", n), RD2, m_rd2);
            chk($sformatf("rnd%0d_rv2", n), 32'(RV2), 32'(m_rv2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
